// File: rtl/stoch_spike_encoder.sv
// stoch_spike_encoder: Bernoulli rate encoder. Each channel draws one random sample per timestep and spikes when sample < rate.
// Latency: spike_valid rises NUM_CH+1 cycles after the edge that samples step_start, when a sample arrives every cycle.
// Backpressure: none. The FSM stalls in WAIT_RND while rnd_valid is low. Optional macro SPIKE_REFRACTORY_EN suppresses repeat spikes.
module stoch_spike_encoder #(
    parameter int NUM_CH = 8,
    parameter int RND_W  = 13,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [RND_W-1:0]  i_rnd,
    input  logic              i_rnd_valid,
    input  logic              i_step_start,
    input  logic              i_rate_wr_en,
    input  logic [CH_W-1:0]   i_rate_wr_addr,
    input  logic [RND_W-1:0]  i_rate_wr_data,
    output logic              o_busy,
    output logic              o_spike_valid,
    output logic [NUM_CH-1:0] o_spike_vec,
    output logic [15:0]       o_step_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RND = 2'd1,
        S_EMIT     = 2'd2
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t              r_state;
    logic [CH_W-1:0]     r_ch;
    logic [NUM_CH-1:0]   r_work;
    logic                r_spike_valid;
    logic [NUM_CH-1:0]   r_spike_vec;
    logic [15:0]         r_step_count;
    logic [RND_W-1:0]    r_rate [NUM_CH];
`ifdef SPIKE_REFRACTORY_EN
    // Bits that spiked in the most recently emitted step.
    logic [NUM_CH-1:0]   r_refr;
`endif

    logic                w_hit;

    // Per-channel firing decision. The table is read before any same-cycle write lands.
`ifdef SPIKE_REFRACTORY_EN
    assign w_hit = (i_rnd < r_rate[r_ch]) && !r_refr[r_ch];
`else
    assign w_hit = (i_rnd < r_rate[r_ch]);
`endif

    // Rate table: writable in any state, cleared by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_rate[i] <= '0;
            end
        end else if (i_rate_wr_en) begin
            r_rate[i_rate_wr_addr] <= i_rate_wr_data;
        end
    end

    // Step sequencer: collect one sample per channel, then publish the vector for one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_ch          <= '0;
            r_work        <= '0;
            r_spike_valid <= 1'b0;
            r_spike_vec   <= '0;
            r_step_count  <= '0;
`ifdef SPIKE_REFRACTORY_EN
            r_refr        <= '0;
`endif
        end else begin
            r_spike_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_step_start) begin
                        r_ch    <= '0;
                        r_work  <= '0;
                        r_state <= S_WAIT_RND;
                    end
                end
                S_WAIT_RND: begin
                    if (i_rnd_valid) begin
                        r_work[r_ch] <= w_hit;
                        r_ch         <= r_ch + 1'b1;
                        if (r_ch == LAST_CH) begin
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    r_spike_valid <= 1'b1;
                    r_spike_vec   <= r_work;
                    r_step_count  <= r_step_count + 16'd1;
`ifdef SPIKE_REFRACTORY_EN
                    r_refr        <= r_work;
`endif
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_spike_valid = r_spike_valid;
    assign o_spike_vec   = r_spike_vec;
    assign o_step_count  = r_step_count;

endmodule

// File: tb/tb_stoch_spike_encoder.sv
// tb_stoch_spike_encoder: directed vectors for stoch_spike_encoder with NUM_CH=8, RND_W=13.
// Inputs are driven and outputs are sampled on the falling clock edge.
// Honours SPIKE_REFRACTORY_EN in its expected-value model.
module tb_stoch_spike_encoder;

    logic        clk;
    logic        i_rst_n;
    logic [12:0] i_rnd;
    logic        i_rnd_valid;
    logic        i_step_start;
    logic        i_rate_wr_en;
    logic [2:0]  i_rate_wr_addr;
    logic [12:0] i_rate_wr_data;
    logic        o_busy;
    logic        o_spike_valid;
    logic [7:0]  o_spike_vec;
    logic [15:0] o_step_count;

    int          n_checks;
    int          n_fail;
    logic [15:0] m_cnt;
    logic [7:0]  m_prev;

    typedef struct packed {
        logic [7:0][12:0] rate;
        logic [7:0][12:0] rv;
        logic [7:0]       gap;
        logic [7:0]       hand_vec;
    } vec_t;

    vec_t tbl [5];

    stoch_spike_encoder #(.NUM_CH(8), .RND_W(13)) dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_rnd          (i_rnd),
        .i_rnd_valid    (i_rnd_valid),
        .i_step_start   (i_step_start),
        .i_rate_wr_en   (i_rate_wr_en),
        .i_rate_wr_addr (i_rate_wr_addr),
        .i_rate_wr_data (i_rate_wr_data),
        .o_busy         (o_busy),
        .o_spike_valid  (o_spike_valid),
        .o_spike_vec    (o_spike_vec),
        .o_step_count   (o_step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Writes all eight rates, one per cycle. Call at a falling edge; returns at a falling edge.
    task automatic set_rates(input logic [7:0][12:0] r);
        for (int i = 0; i < 8; i++) begin
            i_rate_wr_en   = 1'b1;
            i_rate_wr_addr = 3'(i);
            i_rate_wr_data = r[i];
            @(negedge clk);
        end
        i_rate_wr_en = 1'b0;
    endtask

    // Runs one timestep. A sample is presented every 'gap' cycles, with junk (rnd=0, valid=0) in between.
    // Stray step_start pulses are injected while busy. Optionally rewrites channel wr_ch's rate
    // in the same cycle its sample is presented. hand is the expected vector without refractory suppression.
    task automatic run_step(input logic [7:0][12:0] rv, input int gap, input int wr_ch,
                            input logic [12:0] wr_data, input logic [7:0] hand);
        int s;
        int n;
        int lat;
        logic [7:0] vec;
        logic [7:0] exp_vec;
`ifdef SPIKE_REFRACTORY_EN
        exp_vec = hand & ~m_prev;
`else
        exp_vec = hand;
`endif
        m_prev = exp_vec;
        m_cnt  = m_cnt + 16'd1;
        s = 0; n = 0; lat = -1; vec = '0;
        i_step_start = 1'b1;
        i_rnd_valid  = 1'b0;
        while (lat < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_after_start", 32'(o_busy), 32'd1);
            if (o_spike_valid) begin
                lat = n - 1;
                vec = o_spike_vec;
                chk("busy_at_emit", 32'(o_busy), 32'd0);
                chk("step_count", 32'(o_step_count), 32'(m_cnt));
            end
            i_step_start = (s < 8) && (n % 5 == 2);
            i_rate_wr_en = 1'b0;
            if (s < 8 && (n % gap) == 0) begin
                i_rnd_valid = 1'b1;
                i_rnd       = rv[s];
                if (wr_ch == s) begin
                    i_rate_wr_en   = 1'b1;
                    i_rate_wr_addr = 3'(s);
                    i_rate_wr_data = wr_data;
                end
                s++;
            end else begin
                i_rnd_valid = (s >= 8);
                i_rnd       = '0;
            end
        end
        i_step_start = 1'b0;
        i_rnd_valid  = 1'b0;
        i_rate_wr_en = 1'b0;
        chk("latency", 32'(lat), 32'(8 * gap + 1));
        chk("spike_vec", 32'(vec), 32'(exp_vec));
        @(negedge clk);
        chk("valid_one_cycle", 32'(o_spike_valid), 32'd0);
        chk("vec_hold", 32'(o_spike_vec), 32'(exp_vec));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; m_cnt = '0; m_prev = '0;
        i_rst_n = 1'b0; i_rnd = '0; i_rnd_valid = 1'b0; i_step_start = 1'b0;
        i_rate_wr_en = 1'b0; i_rate_wr_addr = '0; i_rate_wr_data = '0;

        // Directed table: rates, samples (index 7 first), gap, expected vector.
        tbl[0] = '{rate: {8{13'h1000}}, rv: {8{13'h0FFF}}, gap: 8'd1, hand_vec: 8'hFF};
        tbl[1] = '{rate: {13'h1FFF, {6{13'h0800}}, 13'h0000},
                   rv:   {13'h1FFF, 13'h0000, 13'h0000, 13'h1FFE, 13'h0800, 13'h07FF, 13'h0001, 13'h0000},
                   gap: 8'd1, hand_vec: 8'h66};
        tbl[2] = '{rate: {8{13'h1FFF}},
                   rv:   {13'h1FFE, 13'h1FFE, 13'h1FFE, 13'h1FFE, 13'h1FFF, 13'h1FFE, 13'h1FFE, 13'h1FFE},
                   gap: 8'd14, hand_vec: 8'hF7};
        tbl[3] = '{rate: {13'h1FFF, 13'h1000, 13'h0FFF, 13'h0800, 13'h0400, 13'h0100, 13'h0001, 13'h0000},
                   rv:   {13'h0000, 13'h1000, 13'h0FFE, 13'h0801, 13'h03FF, 13'h0100, 13'h0000, 13'h0000},
                   gap: 8'd3, hand_vec: 8'hAA};
        tbl[4] = '{rate: {8{13'h1000}}, rv: {8{13'h1000}}, gap: 8'd2, hand_vec: 8'h00};

        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_spike_valid), 32'd0);
        chk("rst_vec", 32'(o_spike_vec), 32'd0);
        chk("rst_count", 32'(o_step_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            set_rates(tbl[k].rate);
            run_step(tbl[k].rv, int'(tbl[k].gap), -1, '0, tbl[k].hand_vec);
        end

        // Rewrite of ch2's rate in the cycle its sample is compared: old rate still applies.
        set_rates({8{13'h1000}});
        run_step({8{13'h0FFF}}, 1, 2, 13'h0000, 8'hFF);
        run_step({8{13'h0FFF}}, 1, -1, 13'h0000, 8'hFB);

        // Step counter wrap from 0xFFFF.
        force dut.r_step_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_step_count;
        m_cnt = 16'hFFFF;
        chk("count_preload", 32'(o_step_count), 32'h0000FFFF);
        run_step({8{13'h0FFF}}, 1, -1, 13'h0000, 8'hFB);

        // Mid-step reset after the 4th sample.
        set_rates({8{13'h1FFF}});
        run_step({8{13'h0000}}, 1, -1, 13'h0000, 8'hFF);
        i_step_start = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            i_step_start = 1'b0;
            i_rnd_valid  = (n < 4);
            i_rnd        = '0;
        end
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_valid", 32'(o_spike_valid), 32'd0);
        chk("midrst_vec", 32'(o_spike_vec), 32'd0);
        chk("midrst_count", 32'(o_step_count), 32'd0);
        m_cnt = '0;
        m_prev = '0;
        @(negedge clk);
        i_rst_n = 1'b1;
        // Start is presented together with reset release; rates were cleared so nothing fires.
        run_step({8{13'h0000}}, 1, -1, 13'h0000, 8'h00);

        // Two back-to-back full-rate steps: refractory suppression shows on the second.
        set_rates({8{13'h1FFF}});
        run_step({8{13'h0000}}, 1, -1, 13'h0000, 8'hFF);
        run_step({8{13'h0000}}, 1, -1, 13'h0000, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stoch_spike_encoder.md
STOCH_SPIKE_ENCODER -- requirements
Module: stoch_spike_encoder

Interface
REQ-001 Parameter: NUM_CH, default 8, number of spike channels encoded per timestep (power of 2, 2..16).
REQ-002 Parameter: RND_W, default 13, width of the random sample and the per-channel rate thresholds.
REQ-003 The module SHALL provide these ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rnd  in  RND_W  random sample from the upstream LFSR generator.
- rnd_valid  in  1  marks rnd as a fresh sample for one cycle.
- step_start  in  1  one-cycle pulse that starts encoding of one timestep.
- rate_wr_en  in  1  write strobe for the rate table.
- rate_wr_addr  in  log2(NUM_CH)  channel index for the rate write.
- rate_wr_data  in  RND_W  firing threshold for that channel.
- busy  out  1  high while not in IDLE.
- spike_valid  out  1  one-cycle strobe; spike_vec is complete.
- spike_vec  out  NUM_CH  spike bits, bit i is channel i.
- step_count  out  16  number of timesteps completed.

Function
REQ-004 The FSM SHALL have three states, IDLE, WAIT_RND and EMIT, and SHALL reset to IDLE.
REQ-005 In IDLE, step_start=1 SHALL clear the channel index to 0 and the working spike register to 0, then enter WAIT_RND.
REQ-006 In WAIT_RND, each cycle with rnd_valid=1 SHALL consume exactly one sample for the current channel:
- working bit[ch] = (rnd < rate[ch]), as an unsigned strict less-than.
- ch then increments by 1.
REQ-007 In WAIT_RND, a cycle with rnd_valid=0 SHALL hold all state unchanged; there is no timeout.
REQ-008 When the sample for channel NUM_CH-1 is consumed, the FSM SHALL enter EMIT on the next edge.
REQ-009 In EMIT, for exactly one cycle, the module SHALL:
- assert spike_valid;
- drive spike_vec with the working register;
- increment step_count by 1 modulo 2^16 (0xFFFF wraps to 0x0000);
- return to IDLE.
REQ-010 spike_vec SHALL hold its last emitted value until the next EMIT.
REQ-011 With rnd_valid held at 1, spike_valid SHALL rise NUM_CH+1 cycles after the edge that samples step_start (9 cycles for NUM_CH=8).
REQ-012 step_start SHALL be ignored outside IDLE. rnd_valid SHALL be ignored in IDLE and EMIT. Samples seen outside WAIT_RND are discarded, not queued.
REQ-013 A sample SHALL never be used for more than one channel.
REQ-014 Rate table writes SHALL be accepted in every state on the edge where rate_wr_en=1.
REQ-015 A compare in the same cycle as a write to that same channel SHALL use the pre-write rate value.
REQ-016 Rate boundary behaviour: rate=0 SHALL never spike. rate=2^RND_W-1 SHALL spike for every sample except the all-ones sample.
REQ-017 busy SHALL be 1 exactly when the state is WAIT_RND or EMIT.

Reset
REQ-018 Asserting reset low SHALL asynchronously force all of the following, including mid-step (the partial step is discarded and no spike_valid is produced):
- state = IDLE;
- ch = 0;
- spike_vec = 0;
- spike_valid = 0;
- busy = 0;
- step_count = 0;
- all rate entries = 0;
- working register = 0.
REQ-019 After reset deasserts, the first step_start SHALL be honoured on the first rising edge.

Configuration
REQ-020 Macro SPIKE_REFRACTORY_EN.
- Defined: channel i's output bit SHALL be forced to 0 in any step that follows an emitted step in which bit i was 1. The channel still consumes one sample.
- Undefined: no suppression; the refractory register SHALL be absent.
- A reset clears the refractory history.

Verification
REQ-021 All scenarios below use NUM_CH=8 and RND_W=13.
- Rates all 0x1000, rnd_valid=1, rnd fixed at 0x0FFF, step_start pulse -> spike_vec=0xFF and spike_valid high 9 cycles after start; step_count=1.
- Rates ch0=0 and ch7=0x1FFF, others 0x0800; rnd sequence 0x0000, 0x0001, 0x07FF, 0x0800, 0x1FFE, 0x0000, 0x0000, 0x1FFF -> spike_vec=0x66.
- rnd_valid toggled once every 14 cycles -> spike_valid rises after the 8th sample plus 1 cycle; no sample is reused; step_start pulses while busy=1 are ignored.
- Force step_count to 0xFFFF by running 65535 steps (or preloading in sim), then run one step -> step_count=0x0000.
- reset low after the 4th sample -> all outputs 0 and state IDLE; a new step completes normally with no stale bits.
- With SPIKE_REFRACTORY_EN defined, rates 0x1FFF and rnd=0, two consecutive steps -> spike_vec=0xFF then 0x00; without the macro -> 0xFF then 0xFF.
